// File: rtl/control_sequencer.sv
// control_sequencer: single-cycle control unit for a small MIPS-like core.
// Holds the PC and a three-state sequencer (IDLE, RUN, HALT). In RUN it decodes
// the current instruction into datapath controls and picks the next PC
// (sequential, taken branch or jump) in the same cycle.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset (wins over start)
//   start     leaves IDLE when high
//   inst      instruction at pc, read combinationally from instruction memory
//   zero/msb  ALU result flags used for branch resolution
//   pc        current instruction address
//   regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl  datapath controls
//   halted    high exactly while in HALT
//   illegal   one-cycle pulse when an unknown opcode/funct executes as a NOP
//   retired   instructions executed in RUN, halt excluded
//             (present only when CTRL_RETIRE_CNT_EN is defined)
module control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        msb,
  output logic [31:0] pc,
  output logic        regwrite,
  output logic        regdst,
  output logic        extop,
  output logic        alusrc,
  output logic        memwrite,
  output logic        mem2reg,
  output logic [3:0]  aluctrl,
  output logic        halted,
  output logic        illegal
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBltz  = 6'h01;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpHalt  = 6'h3F;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic [5:0]  op, funct;
  logic [31:0] pc_plus4, branch_target, jump_target;

  // Raw decode of inst, before gating by state.
  logic        d_regwrite, d_regdst, d_extop, d_alusrc, d_memwrite, d_mem2reg;
  logic [3:0]  d_aluctrl;
  logic        d_legal, d_taken, d_jump, d_halt;

  assign op            = inst[31:26];
  assign funct         = inst[5:0];
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};

  always_comb begin
    d_regwrite = 1'b0;
    d_regdst   = 1'b0;
    d_extop    = 1'b0;
    d_alusrc   = 1'b0;
    d_memwrite = 1'b0;
    d_mem2reg  = 1'b0;
    d_aluctrl  = 4'b0000;
    d_legal    = 1'b1;
    d_taken    = 1'b0;
    d_jump     = 1'b0;
    d_halt     = 1'b0;
    case (op)
      OpRtype: begin
        d_regwrite = 1'b1;
        d_regdst   = 1'b1;
        case (funct)
          6'h20:   d_aluctrl = AluAdd;
          6'h22:   d_aluctrl = AluSub;
          6'h24:   d_aluctrl = AluAnd;
          6'h25:   d_aluctrl = AluOr;
          6'h2A:   d_aluctrl = AluSlt;
          default: begin
            // Unknown funct executes as a NOP: drop the write enables again.
            d_regwrite = 1'b0;
            d_regdst   = 1'b0;
            d_legal    = 1'b0;
          end
        endcase
      end
      OpAddi: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_extop    = 1'b1;
        d_aluctrl  = AluAdd;
      end
      OpLw: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_extop    = 1'b1;
        d_mem2reg  = 1'b1;
        d_aluctrl  = AluAdd;
      end
      OpSw: begin
        d_memwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_extop    = 1'b1;
        d_aluctrl  = AluAdd;
      end
      OpBeq: begin
        d_aluctrl = AluSub;
        d_taken   = zero;
      end
      OpBne: begin
        d_aluctrl = AluSub;
        d_taken   = ~zero;
      end
      OpBltz: begin
        d_aluctrl = AluSub;
        d_taken   = msb;
      end
      OpJ:     d_jump = 1'b1;
      OpHalt:  d_halt = 1'b1;
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (d_halt) begin
          state_d = StHalt;
        end else if (d_jump) begin
          pc_d = jump_target;
        end else if (d_taken) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_plus4;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    extop    = 1'b0;
    alusrc   = 1'b0;
    memwrite = 1'b0;
    mem2reg  = 1'b0;
    aluctrl  = 4'b0000;
    illegal  = 1'b0;
    if (state_q == StRun) begin
      regwrite = d_regwrite;
      regdst   = d_regdst;
      extop    = d_extop;
      alusrc   = d_alusrc;
      memwrite = d_memwrite;
      mem2reg  = d_mem2reg;
      aluctrl  = d_aluctrl;
      illegal  = ~d_legal;
    end
  end

  assign halted = (state_q == StHalt);
  assign pc     = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Illegal NOPs retire; the halt instruction itself does not.
  always_comb begin
    retired_d = retired_q;
    if (state_q == StRun && !d_halt) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retired_q <= 32'd0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, zero, msb;
  logic [31:0] inst, inst_hi;
  logic [31:0] pc, pc_hi;
  logic        regwrite, regdst, extop, alusrc, memwrite, mem2reg, halted, illegal;
  logic [3:0]  aluctrl;
  logic        h_regwrite, h_regdst, h_extop, h_alusrc, h_memwrite, h_mem2reg;
  logic        h_halted, h_illegal;
  logic [3:0]  h_aluctrl;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired, retired_hi;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst), .zero(zero), .msb(msb),
    .pc(pc), .regwrite(regwrite), .regdst(regdst), .extop(extop), .alusrc(alusrc),
    .memwrite(memwrite), .mem2reg(mem2reg), .aluctrl(aluctrl),
    .halted(halted), .illegal(illegal)
`ifdef CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  // Second instance, only to reach a PC with nonzero upper nibble for the jump check.
  control_sequencer #(.RESET_PC(32'h4000_0000)) dut_hi (
    .clk(clk), .rst(rst), .start(start), .inst(inst_hi), .zero(zero), .msb(msb),
    .pc(pc_hi), .regwrite(h_regwrite), .regdst(h_regdst), .extop(h_extop),
    .alusrc(h_alusrc), .memwrite(h_memwrite), .mem2reg(h_mem2reg), .aluctrl(h_aluctrl),
    .halted(h_halted), .illegal(h_illegal)
`ifdef CTRL_RETIRE_CNT_EN
    , .retired(retired_hi)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction builders.
  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] o, input logic [15:0] imm);
    return {o, 5'd4, 5'd5, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // ---------------- reference model ----------------
  // Control word: {regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl[3:0]}.
  typedef struct {
    logic [9:0] ctl;
    bit         legal;
    bit         halt;
    bit         jump;
    bit         branch;
    bit         taken;
  } dec_t;

  function automatic dec_t model_decode(input logic [31:0] i, input logic z, input logic m);
    dec_t d;
    logic [5:0] o, f;
    o = i[31:26];
    f = i[5:0];
    d.ctl = 10'b0; d.legal = 1; d.halt = 0; d.jump = 0; d.branch = 0; d.taken = 0;
    if (o == 6'h00) begin
      if      (f == 6'h20) d.ctl = 10'b11_0000_0010;
      else if (f == 6'h22) d.ctl = 10'b11_0000_0110;
      else if (f == 6'h24) d.ctl = 10'b11_0000_0000;
      else if (f == 6'h25) d.ctl = 10'b11_0000_0001;
      else if (f == 6'h2A) d.ctl = 10'b11_0000_0111;
      else d.legal = 0;
    end else if (o == 6'h08) d.ctl = 10'b10_1100_0010;
    else if (o == 6'h23)     d.ctl = 10'b10_1101_0010;
    else if (o == 6'h2B)     d.ctl = 10'b00_1110_0010;
    else if (o == 6'h04 || o == 6'h05 || o == 6'h01) begin
      d.ctl    = 10'b00_0000_0110;
      d.branch = 1;
      d.taken  = (o == 6'h04) ? z : (o == 6'h05) ? !z : m;
    end else if (o == 6'h02) d.jump = 1;
    else if (o == 6'h3F)     d.halt = 1;
    else d.legal = 0;
    return d;
  endfunction

  // Model state: 0 idle, 1 run, 2 halt.
  int          m_state = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ret = 32'h0;

  always @(negedge clk) begin
    dec_t        d;
    logic [9:0]  exp_ctl;
    logic [31:0] offs;
    d = model_decode(inst, zero, msb);
    exp_ctl = (m_state == 1) ? d.ctl : 10'b0;
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("controls", {22'b0, regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl},
          {22'b0, exp_ctl});
      chk("halted", {31'b0, halted}, {31'b0, m_state == 2});
      chk("illegal", {31'b0, illegal}, {31'b0, (m_state == 1) && !d.legal});
`ifdef CTRL_RETIRE_CNT_EN
      chk("retired", retired, m_ret);
`endif
    end
    // Advance model to the state after the coming rising edge.
    if (rst) begin
      m_state = 0;
      m_pc    = 32'h0;
      m_ret   = 32'h0;
    end else if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (d.halt) begin
        m_state = 2;
      end else begin
        m_ret = m_ret + 1;
        offs  = {{16{inst[15]}}, inst[15:0]} * 4;
        if (d.jump)                    m_pc = {m_pc[31:28] + ((m_pc[27:0] + 4) >> 28), 28'b0}
                                              | {4'b0, inst[25:0], 2'b00};
        else if (d.branch && d.taken)  m_pc = m_pc + 4 + offs;
        else                           m_pc = m_pc + 4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] add_i;
    add_i   = rtype(6'h20);
    rst     = 1'b1;
    start   = 1'b0;
    zero    = 1'b0;
    msb     = 1'b0;
    inst    = add_i;
    inst_hi = jtype(26'h0000100);
    repeat (3) step();
    chk_en = 1'b1;
    chk("reset pc", pc, 32'h0);
    chk("reset halted/illegal", {30'b0, halted, illegal}, 32'h0);
    chk("hi reset pc", pc_hi, 32'h4000_0000);

    rst   = 1'b0;
    start = 1'b1;
    step();                                 // IDLE -> RUN, pc holds
    start = 1'b0;
    chk("add ctl", {26'b0, regwrite, regdst, aluctrl}, {26'b0, 1'b1, 1'b1, 4'b0010});
    step();
    chk("add pc 0->4", pc, 32'h4);
    chk("hi jump pc", pc_hi, 32'h4000_0400);
    inst_hi = {6'h3F, 26'h0};
    step();
    chk("hi halted", {31'b0, h_halted}, 32'h1);
    repeat (2) step();                      // pc now 0x10
    chk("pc 0x10", pc, 32'h10);
    chk("hi pc frozen", pc_hi, 32'h4000_0400);

    inst = itype(6'h04, 16'hFFFE); zero = 1'b1; step();
    chk("beq taken", pc, 32'h0C);
    inst = add_i; step();
    inst = itype(6'h04, 16'hFFFE); zero = 1'b0; step();
    chk("beq not taken", pc, 32'h14);
    inst = jtype(26'h8); step();
    chk("j to 0x20", pc, 32'h20);
    inst = itype(6'h01, 16'h3); msb = 1'b1; step();
    msb = 1'b0;
    chk("bltz taken", pc, 32'h30);
    inst = jtype(26'h8); step();
    inst = itype(6'h05, 16'h1); zero = 1'b0; step();
    chk("bne taken", pc, 32'h28);

    inst = {6'h3E, 26'h0}; #1;
    chk("illegal pulse", {30'b0, illegal, memwrite}, 32'h2);
    step();
    chk("illegal pc+4", pc, 32'h2C);
    inst = add_i; #1;
    chk("illegal drops", {31'b0, illegal}, 32'h0);

    inst = jtype(26'h0); step();
    inst = itype(6'h04, 16'hFFFE); zero = 1'b1; step();
    zero = 1'b0;
    chk("branch wraps below 0", pc, 32'hFFFF_FFFC);
    inst = add_i; step();
    chk("pc+4 wraps to 0", pc, 32'h0);
    step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mid-run reset pc", pc, 32'h0);
    chk("hi reset clears halt", {31'b0, h_halted}, 32'h0);
`ifdef CTRL_RETIRE_CNT_EN
    chk("mid-run reset retired", retired, 32'h0);
`endif

    rst = 1'b1; start = 1'b1; step();
    rst = 1'b0; start = 1'b0; step();
    chk("rst beats start: pc", pc, 32'h0);
    chk("rst beats start: idle ctl", {31'b0, regwrite}, 32'h0);

    start = 1'b1; step();
    start = 1'b0; step();
    inst = {6'h3F, 26'h0}; #1;
    chk("halt op ctl", {31'b0, regwrite}, 32'h0);
    step();
    chk("halted next cycle", {31'b0, halted}, 32'h1);
    inst = add_i; start = 1'b1;
    repeat (3) step();
    chk("halt pc frozen", pc, 32'h4);
    chk("halt holds", {31'b0, halted}, 32'h1);
    rst = 1'b1; start = 1'b0; step();
    rst = 1'b0;

    // Randomized phase; the negedge compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      int k;
      k     = $urandom_range(0, 15);
      zero  = 1'($urandom_range(0, 1));
      msb   = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 99) < 2);
      case (k)
        0:  inst = rtype(6'h20);
        1:  inst = rtype(6'h22);
        2:  inst = rtype(6'h24);
        3:  inst = rtype(6'h25);
        4:  inst = rtype(6'h2A);
        5:  inst = itype(6'h08, 16'($urandom));
        6:  inst = itype(6'h23, 16'($urandom));
        7:  inst = itype(6'h2B, 16'($urandom));
        8:  inst = itype(6'h04, 16'($urandom));
        9:  inst = itype(6'h05, 16'($urandom));
        10: inst = itype(6'h01, 16'($urandom));
        11: inst = jtype(26'($urandom));
        12: inst = {6'h00, 20'($urandom), 6'($urandom)};
        13: inst = ($urandom_range(0, 5) == 0) ? {6'h3F, 26'($urandom)} : rtype(6'h20);
        default: inst = $urandom;
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: leaves IDLE when high.
REQ-005 The block SHALL have port inst, input, 32 bits: instruction at pc, read combinationally from instruction memory.
REQ-006 The block SHALL have ports zero and msb, inputs, 1 bit each: ALU result flags returned by datapath.
REQ-007 The block SHALL have port pc, output, 32 bits: current instruction address.
REQ-008 The block SHALL have ports regwrite, regdst, extop, alusrc, memwrite and mem2reg, outputs, 1 bit each: datapath controls.
REQ-009 The block SHALL have port aluctrl, output, 4 bits: ALU operation select.
REQ-010 The block SHALL have ports halted and illegal, outputs, 1 bit each: status flags.

Function
REQ-011 The FSM SHALL have three states, IDLE, RUN and HALT, with these transitions: IDLE->RUN on start=1; RUN->HALT when opcode inst[31:26]=6'h3F; HALT is left only by rst.
REQ-012 In IDLE and HALT, regwrite and memwrite SHALL be 0, pc SHALL hold, and the other controls are don't-care but driven 0.
REQ-013 In RUN, controls SHALL be decoded combinationally from the current inst, so each instruction completes in one cycle.
REQ-014 R-type decoding (op 6'h00, funct inst[5:0]) SHALL be: regwrite=1, regdst=1, alusrc=0, mem2reg=0; aluctrl = 0010 for add (0x20), 0110 for sub (0x22), 0000 for and (0x24), 0001 for or (0x25), 0111 for slt (0x2A).
REQ-015 I-type decoding SHALL be:
- addi 0x08: regwrite=1, alusrc=1, extop=1, aluctrl=0010.
- lw 0x23: regwrite=1, alusrc=1, extop=1, mem2reg=1, aluctrl=0010.
- sw 0x2B: memwrite=1, alusrc=1, extop=1, aluctrl=0010.
REQ-016 Branch decoding SHALL be: beq 0x04, bne 0x05 and bltz 0x01 all use aluctrl=0110, alusrc=0, no writes; taken if zero=1 (beq), zero=0 (bne), msb=1 (bltz).
REQ-017 Jump 0x02 SHALL have no writes and aluctrl=0000.
REQ-018 Next-PC in RUN SHALL be:
- default pc+4;
- taken branch pc+4+(sext(inst[15:0])<<2);
- jump {pc_plus4[31:28], inst[25:0], 2'b00};
- all arithmetic mod 2^32, so wrap past 32'hFFFF_FFFC to 0 is legal.
REQ-019 An unknown opcode or unknown R-type funct SHALL execute as NOP (all controls 0, pc+4) and pulse illegal=1 for that cycle only.
REQ-020 The halt opcode SHALL drive all controls 0 and leave pc unchanged, and halted SHALL be 1 from the following cycle.
REQ-021 halted SHALL be 1 exactly while in HALT.

Reset
REQ-022 On rst=1 at a clock edge, regardless of state, the block SHALL go to IDLE with pc=RESET_PC, halted=0, illegal=0 and all controls 0; this includes reset in mid-RUN.
REQ-023 If rst and start are both high at the same edge, rst SHALL win.

Configuration
REQ-024 When macro CTRL_RETIRE_CNT_EN is defined, the block SHALL add output retired[31:0], which counts instructions executed in RUN (halt excluded, illegal NOPs included), resets to 0, wraps at 2^32 and holds in IDLE/HALT.
REQ-025 When CTRL_RETIRE_CNT_EN is undefined, the retired port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-026 Reset then start=1 with inst=add (op 0, funct 0x20) SHALL give regwrite=1, regdst=1, aluctrl=0010, and pc SHALL go 0->4 at the next edge.
REQ-027 At pc=0x10, beq with imm=16'hFFFE and zero=1 SHALL give next pc=0x0C; the same with zero=0 SHALL give next pc=0x14.
REQ-028 bltz with msb=1 and imm=3 at pc=0x20 SHALL give next pc=0x30; bne with zero=0 and imm=1 at pc=0x20 SHALL give next pc=0x28.
REQ-029 At pc=0x4000_0000, j with target 26'h0000100 SHALL give next pc=0x4000_0400; opcode 0x3F SHALL give halted=1 with pc frozen until rst.
REQ-030 Opcode 0x3E SHALL pulse illegal=1 for one cycle with memwrite=0 and pc+4; rst asserted mid-RUN SHALL return pc to RESET_PC in the same edge and retired to 0 when CTRL_RETIRE_CNT_EN is defined.
